// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the pipeline control blocks
//
// Purpose: holds the zero-register index, the hazard-unit FSM encodings and
// the default widths shared by the hazard unit and its counters.
// Ports: none (package).
package cpu_pkg;

  // X31 reads as zero, so it can never carry a true dependency.
  localparam logic [4:0] XZR = 5'd31;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    HDU_RUN        = 2'b00,
    HDU_LOAD_STALL = 2'b01,
    HDU_MEM_WAIT   = 2'b10
  } hdu_state_t;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// rtl/hazard_detection_unit_if.sv - pipeline-side signal bundle of the hazard unit
//
// Purpose: groups the hazard inputs coming from the pipeline registers and
// the stall/flush controls going back to them.
// Modports:
//   slave  - hazard unit: reads hazard inputs, drives controls
//   master - pipeline: drives hazard inputs, reads controls
interface hazard_detection_unit_if;

  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRd;
  logic [4:0] IF_ID_RegisterRn1;
  logic [4:0] IF_ID_RegisterRm2;
  logic       IF_ID_UsesRm2;
  logic       EX_MEM_BranchTaken;
  logic       EX_MEM_MemAccess;
  logic       dmem_ready;

  logic       PCWrite;
  logic       IF_ID_Write;
  logic       ID_EX_Bubble;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       EX_MEM_Flush;
  logic       Pipe_Freeze;

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           IF_ID_UsesRm2, EX_MEM_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, Pipe_Freeze
  );

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRn1, IF_ID_RegisterRm2,
           IF_ID_UsesRm2, EX_MEM_BranchTaken, EX_MEM_MemAccess, dmem_ready,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Flush, Pipe_Freeze
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts up by one per enabled cycle and sticks at all-ones.
// Ports:
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset
//   inc    - increment this cycle
//   clr    - synchronous clear, wins over inc
//   count  - current value
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use / branch / memory-wait stall and flush control
//
// Purpose: resolves the hazards operand forwarding cannot: load-use in ID,
// taken branches resolved in MEM and data-memory wait states. Controls are
// combinational; the FSM state, counters and watchdog are registered.
// Ports:
//   CLOCK, RESET_n   - clock and synchronous active-low reset
//   bus              - pipeline hazard inputs and stall/flush controls
//   cnt_clear        - synchronous clear of counters and mem_timeout
//   hdu_state        - FSM state (00 RUN, 01 LOAD_STALL, 10 MEM_WAIT)
//   stall_cycles     - saturating count of load-use stall cycles
//   flush_events     - saturating count of branch flush cycles
//   mem_wait_cycles  - saturating count of memory wait cycles
//   mem_timeout      - sticky flag: MEM_TIMEOUT consecutive wait cycles seen
module hazard_detection_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                    CLOCK,
  input  logic                    RESET_n,
  hazard_detection_unit_if.slave  bus,
  input  logic                    cnt_clear,
  output logic [1:0]              hdu_state,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_events,
  output logic [CNT_W-1:0]        mem_wait_cycles,
  output logic                    mem_timeout
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  hdu_state_t      state;
  hdu_state_t      state_next;
  logic            load_use;
  logic            mem_stall;
  logic            branch;
  logic            do_load_stall;
  logic            do_flush;
  logic [WD_W-1:0] wd_count;
  logic            wd_expire;

  always_comb begin
    load_use  = bus.ID_EX_MemRead && (bus.ID_EX_RegisterRd != XZR) &&
                ((bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRn1) ||
                 (bus.IF_ID_UsesRm2 && (bus.ID_EX_RegisterRd == bus.IF_ID_RegisterRm2)));
    mem_stall = bus.EX_MEM_MemAccess && !bus.dmem_ready;
    branch    = bus.EX_MEM_BranchTaken;

    // A pending branch sits frozen in MEM during a wait; a load-use under a
    // taken branch is moot because both its instructions get squashed.
    do_flush      = branch && !mem_stall;
    do_load_stall = load_use && !branch && !mem_stall;
  end

  always_comb begin
    bus.PCWrite      = 1'b1;
    bus.IF_ID_Write  = 1'b1;
    bus.ID_EX_Bubble = 1'b0;
    bus.IF_ID_Flush  = 1'b0;
    bus.ID_EX_Flush  = 1'b0;
    bus.EX_MEM_Flush = 1'b0;
    bus.Pipe_Freeze  = 1'b0;
    if (RESET_n) begin
      if (mem_stall) begin
        bus.Pipe_Freeze = 1'b1;
        bus.PCWrite     = 1'b0;
        bus.IF_ID_Write = 1'b0;
      end else if (do_flush) begin
        bus.IF_ID_Flush  = 1'b1;
        bus.ID_EX_Flush  = 1'b1;
        bus.EX_MEM_Flush = 1'b1;
      end else if (do_load_stall) begin
        bus.PCWrite      = 1'b0;
        bus.IF_ID_Write  = 1'b0;
        bus.ID_EX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_n) begin
      state <= HDU_RUN;
    end else begin
      state <= state_next;
    end
  end

  // LOAD_STALL needs no explicit exit: the bubble clears ID_EX_MemRead, so
  // load_use drops and the next-state falls back to RUN on its own.
  always_comb begin
    state_next = HDU_RUN;
    if (mem_stall) begin
      state_next = HDU_MEM_WAIT;
    end else if (load_use && !branch) begin
      state_next = HDU_LOAD_STALL;
    end
  end

  assign hdu_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (CLOCK),
    .resetn (RESET_n),
    .inc    (do_load_stall),
    .clr    (cnt_clear),
    .count  (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk    (CLOCK),
    .resetn (RESET_n),
    .inc    (do_flush),
    .clr    (cnt_clear),
    .count  (flush_events)
  );

  sat_counter #(.CNT_W(CNT_W)) u_memw_cnt (
    .clk    (CLOCK),
    .resetn (RESET_n),
    .inc    (mem_stall),
    .clr    (cnt_clear),
    .count  (mem_wait_cycles)
  );

  // Run length of the current wait; any non-waiting cycle restarts it.
  sat_counter #(.CNT_W(WD_W)) u_watchdog (
    .clk    (CLOCK),
    .resetn (RESET_n),
    .inc    (mem_stall),
    .clr    (!mem_stall),
    .count  (wd_count)
  );

  // Raised at the edge where the run count becomes MEM_TIMEOUT.
  assign wd_expire = mem_stall && (wd_count >= WD_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLOCK) begin
    if (!RESET_n) begin
      mem_timeout <= 1'b0;
    end else if (cnt_clear) begin
      mem_timeout <= 1'b0;
    end else if (wd_expire) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - scoreboard bench for hazard_detection_unit
module tb_hazard_detection_unit;

  localparam logic [6:0] DEF = 7'b1100000;
  localparam logic [6:0] LU  = 7'b0010000;
  localparam logic [6:0] BR  = 7'b1101110;
  localparam logic [6:0] MS  = 7'b0000001;

  logic clk = 1'b0;
  logic resetn;
  logic cnt_clear;

  hazard_detection_unit_if bus_a ();
  hazard_detection_unit_if bus_b ();

  logic [1:0]  st_a, st_b;
  logic [15:0] stall_a, flush_a, memw_a;
  logic [1:0]  stall_b, flush_b, memw_b;
  logic        to_a, to_b;

  always #5 clk = ~clk;

  hazard_detection_unit dut_a (
    .CLOCK           (clk),
    .RESET_n         (resetn),
    .bus             (bus_a),
    .cnt_clear       (cnt_clear),
    .hdu_state       (st_a),
    .stall_cycles    (stall_a),
    .flush_events    (flush_a),
    .mem_wait_cycles (memw_a),
    .mem_timeout     (to_a)
  );

  hazard_detection_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
    .CLOCK           (clk),
    .RESET_n         (resetn),
    .bus             (bus_b),
    .cnt_clear       (cnt_clear),
    .hdu_state       (st_b),
    .stall_cycles    (stall_b),
    .flush_events    (flush_b),
    .mem_wait_cycles (memw_b),
    .mem_timeout     (to_b)
  );

  assign bus_b.ID_EX_MemRead      = bus_a.ID_EX_MemRead;
  assign bus_b.ID_EX_RegisterRd   = bus_a.ID_EX_RegisterRd;
  assign bus_b.IF_ID_RegisterRn1  = bus_a.IF_ID_RegisterRn1;
  assign bus_b.IF_ID_RegisterRm2  = bus_a.IF_ID_RegisterRm2;
  assign bus_b.IF_ID_UsesRm2      = bus_a.IF_ID_UsesRm2;
  assign bus_b.EX_MEM_BranchTaken = bus_a.EX_MEM_BranchTaken;
  assign bus_b.EX_MEM_MemAccess   = bus_a.EX_MEM_MemAccess;
  assign bus_b.dmem_ready         = bus_a.dmem_ready;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic [1:0] st;
    int         stall;
    int         flush;
    int         memw;
    bit         to_a;
    int         stall_b;
    bit         to_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int e_stall, e_flush, e_memw, e_stall_b;
  bit e_toa, e_tob;

  task automatic chk(input string vec, input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d required %0d", vec, what, act, req);
    end
  endtask

  // Monitor: the controls are live every cycle, so one expectation is retired
  // per falling edge whenever one is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "ctrl_a", {bus_a.PCWrite, bus_a.IF_ID_Write, bus_a.ID_EX_Bubble,
          bus_a.IF_ID_Flush, bus_a.ID_EX_Flush, bus_a.EX_MEM_Flush, bus_a.Pipe_Freeze}, e.ctrl);
      chk(e.name, "ctrl_b", {bus_b.PCWrite, bus_b.IF_ID_Write, bus_b.ID_EX_Bubble,
          bus_b.IF_ID_Flush, bus_b.ID_EX_Flush, bus_b.EX_MEM_Flush, bus_b.Pipe_Freeze}, e.ctrl);
      chk(e.name, "hdu_state", st_a, e.st);
      chk(e.name, "stall_cycles", stall_a, e.stall);
      chk(e.name, "flush_events", flush_a, e.flush);
      chk(e.name, "mem_wait_cycles", memw_a, e.memw);
      chk(e.name, "mem_timeout", to_a, e.to_a);
      chk(e.name, "stall_cycles_w2", stall_b, e.stall_b);
      chk(e.name, "mem_timeout_t4", to_b, e.to_b);
    end
  end

  logic lu_model;
  assign lu_model = bus_a.ID_EX_MemRead && (bus_a.ID_EX_RegisterRd != 5'd31) &&
                    ((bus_a.ID_EX_RegisterRd == bus_a.IF_ID_RegisterRn1) ||
                     (bus_a.IF_ID_UsesRm2 && (bus_a.ID_EX_RegisterRd == bus_a.IF_ID_RegisterRm2)));

  always @(negedge clk) begin
    if (resetn && (st_a == 2'b01)) begin
      assert (!lu_model) else $error("load-use presented while already in LOAD_STALL");
    end
  end

  task automatic drv(input logic rn, input logic cl, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rn1, input logic [4:0] rm2, input logic us,
                     input logic br, input logic ma, input logic rdy);
    @(posedge clk);
    #1;
    resetn                   = rn;
    cnt_clear                = cl;
    bus_a.ID_EX_MemRead      = mr;
    bus_a.ID_EX_RegisterRd   = rd;
    bus_a.IF_ID_RegisterRn1  = rn1;
    bus_a.IF_ID_RegisterRm2  = rm2;
    bus_a.IF_ID_UsesRm2      = us;
    bus_a.EX_MEM_BranchTaken = br;
    bus_a.EX_MEM_MemAccess   = ma;
    bus_a.dmem_ready         = rdy;
  endtask

  task automatic push(input string nm, input logic [6:0] c, input logic [1:0] s);
    exp_t e;
    e.name = nm; e.ctrl = c; e.st = s;
    e.stall = e_stall; e.flush = e_flush; e.memw = e_memw; e.to_a = e_toa;
    e.stall_b = e_stall_b; e.to_b = e_tob;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic cl);
    drv(1'b1, cl, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    e_stall = 0; e_flush = 0; e_memw = 0; e_stall_b = 0; e_toa = 0; e_tob = 0;
    resetn = 1'b0;
    cnt_clear = 1'b0;
    bus_a.ID_EX_MemRead = 1'b0; bus_a.ID_EX_RegisterRd = '0;
    bus_a.IF_ID_RegisterRn1 = '0; bus_a.IF_ID_RegisterRm2 = '0;
    bus_a.IF_ID_UsesRm2 = 1'b0; bus_a.EX_MEM_BranchTaken = 1'b0;
    bus_a.EX_MEM_MemAccess = 1'b0; bus_a.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Held in reset with a memory wait pending: outputs forced to defaults.
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("reset_hold", DEF, 2'b00);
    idle(1'b0); push("idle", DEF, 2'b00);

    // LDUR X3 then ADD reading X3 via Rn1.
    drv(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("load_use_rn1", LU, 2'b00);
    drv(1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_stall = 1; e_stall_b = 1;
    push("bubble1", DEF, 2'b01);
    idle(1'b0); push("after_stall", DEF, 2'b00);

    drv(1'b1, 1'b0, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("xzr_no_stall", DEF, 2'b00);
    drv(1'b1, 1'b0, 1'b1, 5'd3, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    push("rm2_unused", DEF, 2'b00);
    drv(1'b1, 1'b0, 1'b1, 5'd3, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    push("rm2_used", LU, 2'b00);
    idle(1'b0); e_stall = 2; e_stall_b = 2;
    push("bubble2", DEF, 2'b01);

    // Taken branch over a load-use: flush wins, no bubble, no stall count.
    drv(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("branch_over_lu", BR, 2'b00);
    idle(1'b0); e_flush = 1;
    push("after_branch", DEF, 2'b00);

    // Five wait cycles with a taken branch held in MEM.
    drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push("wait0", MS, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      e_memw = i;
      if (i == 4) e_tob = 1;
      push($sformatf("wait%0d", i), MS, 2'b10);
    end
    drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    e_memw = 5;
    push("ready_branch", BR, 2'b10);
    idle(1'b0); e_flush = 2;
    push("after_wait", DEF, 2'b00);

    idle(1'b1); push("clear_cycle", DEF, 2'b00);
    idle(1'b0);
    e_stall = 0; e_flush = 0; e_memw = 0; e_stall_b = 0; e_tob = 0;
    push("after_clear", DEF, 2'b00);

    // Five load-use stalls: narrow counter pins at 3.
    for (int k = 1; k <= 5; k++) begin
      drv(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      push($sformatf("sat_lu%0d", k), LU, 2'b00);
      drv(1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      e_stall = k;
      e_stall_b = (k > 3) ? 3 : k;
      push($sformatf("sat_bub%0d", k), DEF, 2'b01);
    end

    // Clear and increment in the same cycle: clear wins.
    drv(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("clear_vs_inc", LU, 2'b00);
    drv(1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_stall = 0; e_stall_b = 0;
    push("clear_won", DEF, 2'b01);

    // Reset arriving mid-MEM_WAIT.
    drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    push("rwait0", MS, 2'b00);
    drv(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_memw = 1;
    push("rwait1", MS, 2'b10);
    drv(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_memw = 2;
    push("reset_in_wait", DEF, 2'b10);
    idle(1'b0); e_memw = 0;
    push("after_reset", DEF, 2'b00);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
